// File: rtl/rvfpm_xif_rob_if.sv
// Purpose: bundles the issue, completion, result and flush signals of the rvfpm XIF reorder buffer.
// Latency: none (wires only).
// Backpressure: issue uses valid/ready, completion has none, result uses valid/ready.
interface rvfpm_xif_rob_if #(
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  issue_valid;
  logic                  issue_ready;
  logic [X_ID_WIDTH-1:0] issue_id;
  logic [4:0]            issue_rd;

  logic                  done_valid;
  logic [X_ID_WIDTH-1:0] done_id;
  logic [XLEN-1:0]       done_data;
  logic [4:0]            done_fflags;

  logic                  result_valid;
  logic                  result_ready;
  logic [X_ID_WIDTH-1:0] result_id;
  logic [4:0]            result_rd;
  logic [XLEN-1:0]       result_data;
  logic [4:0]            result_fflags;

  logic                  flush;
  logic [CW-1:0]         count;
  logic                  err_unknown_id;

  // Core / pipeline side: offers instructions and completions, consumes results.
  modport master (
    output issue_valid, issue_id, issue_rd,
    output done_valid, done_id, done_data, done_fflags,
    output result_ready, flush,
    input  issue_ready, result_valid, result_id, result_rd, result_data, result_fflags,
    input  count, err_unknown_id
  );

  // Reorder buffer side.
  modport slave (
    input  issue_valid, issue_id, issue_rd,
    input  done_valid, done_id, done_data, done_fflags,
    input  result_ready, flush,
    output issue_ready, result_valid, result_id, result_rd, result_data, result_fflags,
    output count, err_unknown_id
  );
endinterface

// File: rtl/rvfpm_xif_rob.sv
// Purpose: reorder buffer that retires out-of-order rvfpm completions to the XIF core in issue order.
// Latency: completion of the head entry shows as result_valid one cycle later; issue-to-result minimum two cycles.
// Backpressure: issue_ready drops when all DEPTH entries are occupied; results hold stable while result_ready is low.
module rvfpm_xif_rob #(
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4
) (
  input logic           ck,
  input logic           rst,
  rvfpm_xif_rob_if.slave xif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  ent_valid  [DEPTH];
  logic                  ent_done   [DEPTH];
  logic [X_ID_WIDTH-1:0] ent_id     [DEPTH];
  logic [4:0]            ent_rd     [DEPTH];
  logic [XLEN-1:0]       ent_data   [DEPTH];
  logic [4:0]            ent_fflags [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          err_q;

  logic          issue_fire;
  logic          retire_fire;
  logic          match_hit;
  logic [PW-1:0] match_idx;
  logic [PW-1:0] scan_idx;

  // Full-ness is judged from the registered count only, so a same-cycle retire never frees a slot.
  assign xif.issue_ready = !rst && (count < CW'(DEPTH));
  assign issue_fire      = xif.issue_valid && xif.issue_ready;

  // Head entry registers feed the result port directly; no input reaches these outputs.
  assign xif.result_valid  = ent_valid[head] && ent_done[head];
  assign xif.result_id     = ent_id[head];
  assign xif.result_rd     = ent_rd[head];
  assign xif.result_data   = ent_data[head];
  assign xif.result_fflags = ent_fflags[head];
  assign retire_fire       = xif.result_valid && xif.result_ready;

  assign xif.count          = count;
  assign xif.err_unknown_id = err_q;

  // Find the oldest pending entry (scanning from head) whose id matches the completion.
  always_comb begin
    match_hit = 1'b0;
    match_idx = head;
    scan_idx  = head;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head + PW'(k);
      if (!match_hit && xif.done_valid && ent_valid[scan_idx] && !ent_done[scan_idx] &&
          ent_id[scan_idx] == xif.done_id) begin
        match_hit = 1'b1;
        match_idx = scan_idx;
      end
    end
  end

  // Entry storage, pointers, occupancy and the unknown-id pulse; rst beats flush beats normal updates.
  always_ff @(posedge ck) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i]  <= 1'b0;
        ent_done[i]   <= 1'b0;
        ent_id[i]     <= '0;
        ent_rd[i]     <= '0;
        ent_data[i]   <= '0;
        ent_fflags[i] <= '0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else if (xif.flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i] <= 1'b0;
        ent_done[i]  <= 1'b0;
      end
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      // An entry issued this cycle is not yet valid, so its completion is reported as unknown.
      err_q <= xif.done_valid && !match_hit;

      // Issue, completion and retire never target the same slot in one cycle:
      // issue needs a free slot, completion a pending one, retire a done one.
      if (issue_fire) begin
        ent_valid[tail] <= 1'b1;
        ent_done[tail]  <= 1'b0;
        ent_id[tail]    <= xif.issue_id;
        ent_rd[tail]    <= xif.issue_rd;
        tail            <= tail + 1'b1;
      end
      if (match_hit) begin
        ent_done[match_idx]   <= 1'b1;
        ent_data[match_idx]   <= xif.done_data;
        ent_fflags[match_idx] <= xif.done_fflags;
      end
      if (retire_fire) begin
        ent_valid[head] <= 1'b0;
        ent_done[head]  <= 1'b0;
        head            <= head + 1'b1;
      end
      count <= count + CW'(issue_fire) - CW'(retire_fire);
    end
  end
endmodule

// File: tb/tb_rvfpm_xif_rob.sv
// Purpose: self-checking bench for rvfpm_xif_rob using an in-order queue model as scoreboard.
// Latency: one step per clock; outputs checked 1 time unit after inputs change, away from the rising edge.
// Backpressure: result_ready driven per step, including multi-cycle stalls.
module tb_rvfpm_xif_rob;
  localparam int IDW   = 4;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [IDW-1:0]  id;
    logic [4:0]      rd;
    bit              done;
    logic [XLEN-1:0] data;
    logic [4:0]      ff;
  } ent_t;

  logic ck;
  logic rst;
  int   n_chk;
  int   n_err;
  bit   err_exp;
  ent_t mq[$];

  rvfpm_xif_rob_if #(.X_ID_WIDTH(IDW), .XLEN(XLEN), .DEPTH(DEPTH)) x ();

  rvfpm_xif_rob #(.X_ID_WIDTH(IDW), .XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .ck  (ck),
    .rst (rst),
    .xif (x)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model, cross the edge.
  task automatic step(input bit iv, input logic [IDW-1:0] iid, input logic [4:0] ird,
                      input bit dv, input logic [IDW-1:0] did, input logic [XLEN-1:0] dd,
                      input logic [4:0] df, input bit rr, input bit fl, input bit r);
    bit   exp_rv;
    bit   do_issue;
    bit   do_retire;
    bit   hit;
    ent_t e;
    ent_t popped;
    rst              = r;
    x.issue_valid    = iv;
    x.issue_id       = iid;
    x.issue_rd       = ird;
    x.done_valid     = dv;
    x.done_id        = did;
    x.done_data      = dd;
    x.done_fflags    = df;
    x.result_ready   = rr;
    x.flush          = fl;
    #1;
    exp_rv = (mq.size() > 0) && mq[0].done;
    if (r) chk("irdy_rst", x.issue_ready, 0);
    else   chk("irdy", x.issue_ready, (mq.size() < DEPTH));
    chk("count", x.count, mq.size());
    chk("rvalid", x.result_valid, exp_rv);
    chk("err", x.err_unknown_id, err_exp);
    if (exp_rv) begin
      chk("rid", x.result_id, mq[0].id);
      chk("rrd", x.result_rd, mq[0].rd);
      chk("rdata", x.result_data, mq[0].data);
      chk("rflags", x.result_fflags, mq[0].ff);
    end
    if (r || fl) begin
      mq.delete();
      err_exp = 1'b0;
    end else begin
      do_retire = exp_rv && rr;
      do_issue  = iv && (mq.size() < DEPTH);
      hit       = 1'b0;
      if (dv) begin
        for (int k = 0; k < mq.size(); k++) begin
          if (!hit && !mq[k].done && mq[k].id == did) begin
            mq[k].done = 1'b1;
            mq[k].data = dd;
            mq[k].ff   = df;
            hit        = 1'b1;
          end
        end
      end
      err_exp = dv && !hit;
      if (do_retire) popped = mq.pop_front();
      if (do_issue) begin
        e.id   = iid;
        e.rd   = ird;
        e.done = 1'b0;
        e.data = '0;
        e.ff   = '0;
        mq.push_back(e);
      end
    end
    @(posedge ck);
    @(negedge ck);
  endtask

  task automatic iss(input logic [IDW-1:0] id, input logic [4:0] rd);
    step(1, id, rd, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic cmp(input logic [IDW-1:0] id, input logic [XLEN-1:0] d, input logic [4:0] f);
    step(0, 0, 0, 1, id, d, f, 1, 0, 0);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic zero_fields(input string tag);
    chk({tag, "_rid"}, x.result_id, 0);
    chk({tag, "_rrd"}, x.result_rd, 0);
    chk({tag, "_rdata"}, x.result_data, 0);
    chk({tag, "_rflags"}, x.result_fflags, 0);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    err_exp = 1'b0;
    rst = 1'b1;
    x.issue_valid = 0; x.issue_id = 0; x.issue_rd = 0;
    x.done_valid = 0; x.done_id = 0; x.done_data = 0; x.done_fflags = 0;
    x.result_ready = 0; x.flush = 0;
    @(posedge ck);
    @(posedge ck);
    @(negedge ck);
    chk("reset_irdy", x.issue_ready, 0);
    chk("reset_count", x.count, 0);
    chk("reset_rvalid", x.result_valid, 0);
    chk("reset_err", x.err_unknown_id, 0);
    zero_fields("reset");

    // In order: issue 1,2,3 overlapped with completions.
    step(1, 1, 5, 0, 0, 0, 0, 1, 0, 0);
    step(1, 2, 6, 1, 1, 32'h3F80_0000, 5'h00, 1, 0, 0);
    step(1, 3, 7, 1, 2, 32'h4000_0000, 5'h01, 1, 0, 0);
    cmp(3, 32'h4040_0000, 5'h02);
    nop(3);

    // Out of order: complete 6,4,5; nothing retires until 4 is done.
    iss(4, 10); iss(5, 11); iss(6, 12);
    cmp(6, 32'h6666_6666, 5'h10);
    nop(1);
    cmp(4, 32'h4444_4444, 5'h04);
    cmp(5, 32'h5555_5555, 5'h08);
    nop(4);

    // Full: four entries, then a same-cycle retire must not admit id 5.
    iss(1, 1); iss(2, 2); iss(3, 3); iss(4, 4);
    step(1, 5, 5, 1, 1, 32'hA1, 5'h01, 0, 0, 0);
    step(1, 5, 5, 0, 0, 0, 0, 1, 0, 0);
    step(1, 5, 5, 0, 0, 0, 0, 0, 0, 0);
    cmp(2, 32'hA2, 5'h02); cmp(3, 32'hA3, 5'h03);
    cmp(4, 32'hA4, 5'h04); cmp(5, 32'hA5, 5'h05);
    nop(5);

    // Stall: completed head held for five cycles with result_ready low.
    iss(7, 17);
    step(0, 0, 0, 1, 7, 32'hDEAD_BEEF, 5'h1F, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(2);

    // Unknown id, then duplicate in-flight ids bound oldest first.
    cmp(9, 32'h9, 5'h0);
    nop(2);
    iss(2, 8); iss(2, 9);
    step(0, 0, 0, 1, 2, 32'hAA, 5'h03, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(1);
    cmp(2, 32'hBB, 5'h06);
    nop(2);

    // Completion of an instruction issued in the same cycle is unknown.
    step(1, 3, 3, 1, 3, 32'h33, 5'h0, 1, 0, 0);
    cmp(3, 32'h33, 5'h0);
    nop(2);

    // Flush with a same-cycle completion: no error, everything dropped.
    iss(1, 1); iss(2, 2); iss(3, 3);
    step(1, 4, 4, 1, 1, 32'h11, 5'h1, 1, 1, 0);
    nop(3);

    // Reset mid-stream.
    iss(1, 1); iss(2, 2);
    cmp(1, 32'h77, 5'h7);
    step(1, 3, 3, 1, 2, 32'h88, 5'h8, 1, 0, 1);
    zero_fields("midrst");
    nop(2);
    iss(5, 21);
    cmp(5, 32'h1234_5678, 5'h2);
    nop(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
